// File: rtl/angle_scheduler.sv
// angle_scheduler: derives an angular slot index from a once-per-revolution
// hall index pulse. The revolution period is measured in clk cycles and
// divided into NB_ANGLES equal slots. The slot index (angle) restarts at every
// accepted index edge and saturates at the last slot if the next edge is late.
module angle_scheduler #(
  parameter int NB_ANGLES    = 128,
  parameter int PERIOD_WIDTH = 24,
  parameter int MIN_PERIOD   = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         hall,
  output logic [$clog2(NB_ANGLES)-1:0] angle,
  output logic                         angle_valid,
  output logic                         fc_en,
  output logic [PERIOD_WIDTH-1:0]      period
);

  localparam int AW = $clog2(NB_ANGLES);
  localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE   = PERIOD_WIDTH'(1);
  localparam logic [AW-1:0]           ANGLE_MAX = AW'(NB_ANGLES - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_SYNC    = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Hall synchronizer and edge detection
  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic       index_edge;

  // Datapath registers
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] slot_len_q, slot_len_d;
  logic [PERIOD_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
  logic [AW-1:0]           angle_q, angle_d;
  logic                    fc_en_q, fc_en_d;

  logic cnt_sat;
  logic accept;
  logic rev_edge;

  // Two-flop synchronizer, previous-value register and arming logic.
  // settle_q marks the point where sync2_q reflects the real hall level; the
  // detector only arms after seeing hall low, so a hall already high when
  // reset is released never looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= hall;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      settle_q <= {settle_q[0], 1'b1};
      armed_q  <= armed_q | (settle_q[1] & ~sync2_q);
    end
  end

  assign index_edge = sync2_q & ~prev_q & armed_q;
  assign cnt_sat    = (cnt_q == CNT_MAX);
  // Any edge starts things from STOPPED; afterwards edges arriving too soon
  // after the previous accepted one are treated as glitches.
  assign accept     = index_edge & ((state_q == ST_STOPPED) | (cnt_q >= MIN_P));
  // Accepted edge that closes a measured revolution (enters or stays in RUN)
  assign rev_edge   = accept & (state_q != ST_STOPPED);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STOPPED;
    else        state_q <= state_d;
  end

  // Next-state logic: an accepted edge takes priority over counter saturation
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: if (accept) state_d = ST_SYNC;
      ST_SYNC: begin
        if (accept)       state_d = ST_RUN;
        else if (cnt_sat) state_d = ST_STOPPED;
      end
      ST_RUN: begin
        if (accept)       state_d = ST_RUN;
        else if (cnt_sat) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    angle_valid = (state_q == ST_RUN);
  end

  // Next values for period counter, period/slot-length capture and slot stepping
  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    slot_len_d = slot_len_q;
    slot_cnt_d = slot_cnt_q;
    angle_d    = angle_q;
    fc_en_d    = 1'b0;

    if (accept)                   cnt_d = CNT_ONE;
    else if (state_q == ST_STOPPED) cnt_d = '0;
    else if (!cnt_sat)            cnt_d = cnt_q + CNT_ONE;

    if (rev_edge) begin
      period_d   = cnt_q;
      slot_len_d = cnt_q >> AW;
      slot_cnt_d = '0;
      angle_d    = '0;
      fc_en_d    = 1'b1;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (slot_cnt_q == slot_len_q - CNT_ONE) begin
        slot_cnt_d = '0;
        // Late edge: park on the last slot rather than wrapping
        if (angle_q != ANGLE_MAX) angle_d = angle_q + AW'(1);
      end else begin
        slot_cnt_d = slot_cnt_q + CNT_ONE;
      end
    end else begin
      slot_cnt_d = '0;
      angle_d    = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      period_q   <= '0;
      slot_len_q <= '0;
      slot_cnt_q <= '0;
      angle_q    <= '0;
      fc_en_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      slot_len_q <= slot_len_d;
      slot_cnt_q <= slot_cnt_d;
      angle_q    <= angle_d;
      fc_en_q    <= fc_en_d;
    end
  end

  assign angle  = angle_q;
  assign fc_en  = fc_en_q;
  assign period = period_q;

endmodule

// File: tb/tb_angle_scheduler.sv
// Directed bench for angle_scheduler. Two instances share clk and rst_n:
// dut_a covers the main sequence including the stall, while dut_b receives an
// extra index edge exactly when its period counter saturates, so both long
// saturation cases run in the same time window.
module tb_angle_scheduler;

  localparam int NB   = 128;
  localparam int PW   = 16;
  localparam int MINP = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          hall_a, hall_b;
  logic [6:0]    angle_a, angle_b;
  logic          valid_a, valid_b;
  logic          fc_en_a, fc_en_b;
  logic [PW-1:0] period_a, period_b;

  int n_checks = 0;
  int n_errors = 0;

  angle_scheduler #(.NB_ANGLES(NB), .PERIOD_WIDTH(PW), .MIN_PERIOD(MINP)) dut_a (
    .clk(clk), .rst_n(rst_n), .hall(hall_a),
    .angle(angle_a), .angle_valid(valid_a), .fc_en(fc_en_a), .period(period_a)
  );

  angle_scheduler #(.NB_ANGLES(NB), .PERIOD_WIDTH(PW), .MIN_PERIOD(MINP)) dut_b (
    .clk(clk), .rst_n(rst_n), .hall(hall_b),
    .angle(angle_b), .angle_valid(valid_b), .fc_en(fc_en_b), .period(period_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs driven and outputs sampled 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  // Raise hall on the selected inputs; the edge takes effect on the 3rd clock
  task automatic pulse(input logic on_a, input logic on_b);
    if (on_a) hall_a = 1'b1;
    if (on_b) hall_b = 1'b1;
    wait_n(3);
    hall_a = 1'b0;
    hall_b = 1'b0;
    $display("edge  t=%0t a: angle=%0d valid=%0b fc=%0b period=%0d", $time,
             angle_a, valid_a, fc_en_a, period_a);
  endtask

  // One revolution of p cycles from an accepted edge to the next one
  task automatic spin(input int p, output int n127, output int nfc,
                      output int a10, output int a1269);
    n127  = 0;
    nfc   = 0;
    a10   = -1;
    a1269 = -1;
    for (int off = 1; off <= p; off++) begin
      step();
      if (off < p) begin
        if (angle_a == 7'd127) n127++;
        if (fc_en_a) nfc++;
      end
      if (off == 10)   a10   = int'(angle_a);
      if (off == 1269) a1269 = int'(angle_a);
      if (off == p - 3) begin
        hall_a = 1'b1;
        hall_b = 1'b1;
      end
    end
    hall_a = 1'b0;
    hall_b = 1'b0;
    $display("rev   t=%0t p=%0d n127=%0d nfc=%0d a10=%0d a1269=%0d period=%0d", $time,
             p, n127, nfc, a10, a1269, period_a);
  endtask

  int n127, nfc, a10, a1269;

  initial begin
    rst_n  = 1'b0;
    hall_a = 1'b1;
    hall_b = 1'b1;
    wait_n(3);
    check("rst_angle",  angle_a,  0);
    check("rst_valid",  valid_a,  0);
    check("rst_fc",     fc_en_a,  0);
    check("rst_period", period_a, 0);

    // Hall already high at release must not count as an edge
    rst_n = 1'b1;
    wait_n(300);
    hall_a = 1'b0;
    hall_b = 1'b0;
    wait_n(10);

    // First real edge: STOPPED -> SYNC only
    pulse(1'b1, 1'b1);
    check("sync_valid",  valid_a,  0);
    check("sync_fc",     fc_en_a,  0);
    check("sync_angle",  angle_a,  0);
    check("sync_period", period_a, 0);

    // Second edge 1280 cycles later: SYNC -> RUN
    wait_n(1277);
    pulse(1'b1, 1'b1);
    check("run_valid",  valid_a,  1);
    check("run_fc",     fc_en_a,  1);
    check("run_angle",  angle_a,  0);
    check("run_period", period_a, 1280);

    // Steady revolution at 1280: L=10, angle reaches 127 at offset 1270
    spin(1280, n127, nfc, a10, a1269);
    check("rev1280_a10",    a10,   1);
    check("rev1280_a1269",  a1269, 126);
    check("rev1280_n127",   n127,  10);
    check("rev1280_nfc",    nfc,   0);
    check("rev1280_angle",  angle_a,  0);
    check("rev1280_fc",     fc_en_a,  1);
    check("rev1280_period", period_a, 1280);

    // Glitch 100 cycles after an accepted edge is ignored
    wait_n(97);
    pulse(1'b1, 1'b1);
    check("glitch_angle",  angle_a,  10);
    check("glitch_fc",     fc_en_a,  0);
    check("glitch_period", period_a, 1280);
    check("glitch_valid",  valid_a,  1);

    // Next edge 1300 cycles after the last accepted one: cnt was not restarted
    wait_n(1197);
    pulse(1'b1, 1'b1);
    check("post_glitch_period", period_a, 1300);
    check("post_glitch_fc",     fc_en_a,  1);
    check("post_glitch_angle",  angle_a,  0);

    // Truncation: 1300 >> 7 = 10, so angle parks on 127 for 30 cycles
    spin(1300, n127, nfc, a10, a1269);
    check("rev1300_a10",    a10,   1);
    check("rev1300_a1269",  a1269, 126);
    check("rev1300_n127",   n127,  30);
    check("rev1300_nfc",    nfc,   0);
    check("rev1300_angle",  angle_a,  0);
    check("rev1300_period", period_a, 1300);

    // Stall on dut_a; dut_b gets an edge exactly as its counter saturates
    wait_n(65532);
    hall_b = 1'b1;
    wait_n(2);
    check("stall_pre_valid", valid_a, 1);
    check("stall_pre_angle", angle_a, 127);
    step();
    hall_b = 1'b0;
    $display("stall t=%0t a: valid=%0b period=%0d  b: valid=%0b fc=%0b period=%0d", $time,
             valid_a, period_a, valid_b, fc_en_b, period_b);
    check("stall_valid",  valid_a,  0);
    check("stall_angle",  angle_a,  0);
    check("stall_period", period_a, 1300);
    check("stall_fc",     fc_en_a,  0);
    check("coll_valid",   valid_b,  1);
    check("coll_fc",      fc_en_b,  1);
    check("coll_angle",   angle_b,  0);
    check("coll_period",  period_b, 65535);

    // Two edges bring dut_a back into RUN
    wait_n(20);
    pulse(1'b1, 1'b0);
    check("resync_valid",  valid_a,  0);
    check("resync_fc",     fc_en_a,  0);
    check("resync_period", period_a, 1300);
    wait_n(1277);
    pulse(1'b1, 1'b0);
    check("rerun_valid",  valid_a,  1);
    check("rerun_fc",     fc_en_a,  1);
    check("rerun_period", period_a, 1280);

    // Reset mid-RUN clears outputs before the next clock edge
    wait_n(50);
    check("pre_rst_angle", angle_a, 5);
    rst_n = 1'b0;
    #2;
    $display("reset t=%0t a: angle=%0d valid=%0b fc=%0b period=%0d", $time,
             angle_a, valid_a, fc_en_a, period_a);
    check("midrst_angle",    angle_a,  0);
    check("midrst_valid",    valid_a,  0);
    check("midrst_fc",       fc_en_a,  0);
    check("midrst_period",   period_a, 0);
    check("midrst_b_valid",  valid_b,  0);
    check("midrst_b_period", period_b, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
